cpu_seq_ctrl: RTL

Multi-cycle instruction sequencer for the small CPU. It fetches 16-bit instructions over a req/ack handshake and decodes them. It drives the program counter's enable and control inputs (hold/increment/load, 8-bit jump address) and sequences ALU and accumulator write-back. It also provides halt, illegal-opcode and fetch-timeout status.

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/cpu_seq_ctrl_decode.sv | 34 +++
 rtl/cpu_seq_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU sequencer: opcodes, FSM states, PC and ALU control codes.
// Pure declarations; no timing or flow-control behaviour.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_JNZ  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT,
        ST_FAULT
    } state_t;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/cpu_seq_ctrl_decode.sv
// Opcode classifier: combinational, zero latency; the jump-taken result folds in zero_flag.
// No handshake; results are only meaningful while the sequencer sits in DECODE or EXEC.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_zero_flag,
    output logic       o_is_alu,
    output logic       o_is_jump_taken,
    output logic       o_is_halt,
    output logic       o_is_illegal,
    output logic [1:0] o_alu_op
);

    always_comb begin
        o_is_alu        = 1'b0;
        o_is_jump_taken = 1'b0;
        o_is_halt       = 1'b0;
        o_is_illegal    = 1'b0;
        o_alu_op        = ALU_PASS;
        case (i_opcode)
            OP_NOP:  ;
            OP_LDI:  begin o_is_alu = 1'b1; o_alu_op = ALU_PASS; end
            OP_ADD:  begin o_is_alu = 1'b1; o_alu_op = ALU_ADD;  end
            OP_SUB:  begin o_is_alu = 1'b1; o_alu_op = ALU_SUB;  end
            OP_JMP:  o_is_jump_taken = 1'b1;
            OP_JZ:   o_is_jump_taken = i_zero_flag;
            OP_JNZ:  o_is_jump_taken = ~i_zero_flag;
            OP_HALT: o_is_halt = 1'b1;
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer: 2 cycles for NOP/jumps, 4 for ALU ops (zero-wait ack).
// Fetch stalls on imem_ack for up to FETCH_TIMEOUT cycles, then locks into FAULT until reset.
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    input  logic             zero_flag,
    output logic             pc_en,
    output logic [1:0]       pc_ctrl,
    output logic [7:0]       jump_addr,
    output logic [15:0]      ir,
    output logic             alu_en,
    output logic [1:0]       alu_op,
    output logic             acc_we,
    output logic             halted,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(FETCH_TIMEOUT);

    state_t           r_state;
    logic [15:0]      r_ir;
    logic [7:0]       r_timer;
    logic [CNT_W-1:0] r_cnt;

    logic       w_is_alu;
    logic       w_is_jump_taken;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic [1:0] w_alu_op;
    logic [7:0] w_timer_nxt;

    assign w_timer_nxt = r_timer + 8'd1;

    ctrl_decode u_decode (
        .i_opcode        (r_ir[15:12]),
        .i_zero_flag     (zero_flag),
        .o_is_alu        (w_is_alu),
        .o_is_jump_taken (w_is_jump_taken),
        .o_is_halt       (w_is_halt),
        .o_is_illegal    (w_is_illegal),
        .o_alu_op        (w_alu_op)
    );

    // The count is bumped as the word is accepted so DECODE already shows the new total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
            r_timer <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_timer <= '0;
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= ST_DECODE;
                    end else if (w_timer_nxt == TIMEOUT_LIM) begin
                        r_timer <= '0;
                        r_state <= ST_FAULT;
                    end else begin
                        r_timer <= w_timer_nxt;
                    end
                end
                ST_DECODE: begin
                    if (w_is_halt)     r_state <= ST_HALT;
                    else if (w_is_alu) r_state <= ST_EXEC;
                    else               r_state <= ST_FETCH;
                end
                ST_EXEC:  r_state <= ST_WB;
                ST_WB:    r_state <= ST_FETCH;
                ST_HALT:  if (start) r_state <= ST_FETCH;
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = (r_state == ST_FETCH);
        pc_en     = (r_state == ST_DECODE);
        pc_ctrl   = PC_HOLD;
        jump_addr = 8'h00;
        alu_en    = (r_state == ST_EXEC);
        alu_op    = ALU_PASS;
        acc_we    = (r_state == ST_WB);
        halted    = (r_state == ST_HALT);
        illegal   = 1'b0;
        fault     = (r_state == ST_FAULT);
        if (r_state == ST_DECODE) begin
            illegal = w_is_illegal;
            if (w_is_halt) begin
                pc_ctrl = PC_HOLD;
            end else if (w_is_jump_taken) begin
                pc_ctrl   = PC_LOAD;
                jump_addr = r_ir[7:0];
            end else begin
                pc_ctrl = PC_INC;
            end
        end
        if (r_state == ST_EXEC) alu_op = w_alu_op;
    end

    assign ir        = r_ir;
    assign instr_cnt = r_cnt;

endmodule
